poly_note_gen: RTL

- Multi-channel square-wave tone generator; successor to the single-channel note generator.
- Each of NUM_CH channels takes a note index, octave and duration. It produces a square wave at the equal-tempered pitch for the programmed number of milliseconds, then stops and flags done.
- Feeds the speaker/PWM stage through per-channel outputs and a registered mix count. Sits between the tuner/sequencer control logic and the audio pins.

---
 rtl/poly_note_gen_pkg.sv | 34 +++
 rtl/poly_note_gen_if.sv | 29 ++
 rtl/poly_note_gen_channel.sv | 77 +++++++
 rtl/poly_note_gen.sv | 87 ++++++++
 4 files changed

// File: rtl/poly_note_gen_pkg.sv
// Shared constants and helpers for the polyphonic note generator.
// Pitch table holds octave-2 half-period counts at a 50 MHz clock.
package poly_note_pkg;

  localparam int BASE_W = 20;

  // round(50e6 / (2 * f)) for C2..B2
  localparam logic [BASE_W-1:0] BASE_HALF_PERIOD [0:11] = '{
    20'd382219, 20'd360773, 20'd340524, 20'd321412,
    20'd303373, 20'd286346, 20'd270274, 20'd255105,
    20'd240787, 20'd227273, 20'd214517, 20'd202477
  };

  // Note indices at or above this value are timed rests
  localparam logic [3:0] NOTE_REST = 4'd12;

  // Highest octave field honoured; larger requests clamp here
  localparam logic [2:0] MAX_OCT = 3'd5;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_PLAY = 1'b1
  } ch_state_t;

  function automatic logic [BASE_W-1:0] base_half_period(input logic [3:0] note);
    if (note < NOTE_REST) return BASE_HALF_PERIOD[note];
    return BASE_HALF_PERIOD[0];
  endfunction

  function automatic logic [2:0] clamp_octave(input logic [2:0] oct);
    return (oct > MAX_OCT) ? MAX_OCT : oct;
  endfunction

endpackage

// File: rtl/poly_note_gen_if.sv
// Control/status bundle between the sequencer and the tone generator.
// master = sequencer side, slave = generator side.
interface poly_note_gen_if #(
  parameter int NUM_CH = 4,
  parameter int DUR_W  = 16
);
  localparam int MIX_W = $clog2(NUM_CH + 1);

  logic [4*NUM_CH-1:0]     note_idx;
  logic [3*NUM_CH-1:0]     octave;
  logic [DUR_W*NUM_CH-1:0] duration;
  logic [NUM_CH-1:0]       start;
  logic [NUM_CH-1:0]       stop;
  logic [NUM_CH-1:0]       busy;
  logic [NUM_CH-1:0]       done;
  logic [NUM_CH-1:0]       audio_out;
  logic [MIX_W-1:0]        audio_mix;

  modport master (
    output note_idx, octave, duration, start, stop,
    input  busy, done, audio_out, audio_mix
  );

  modport slave (
    input  note_idx, octave, duration, start, stop,
    output busy, done, audio_out, audio_mix
  );

endinterface

// File: rtl/poly_note_gen_channel.sv
// One tone channel: IDLE/PLAY state, half-period phase counter and
// millisecond countdown. Pitch and rest flag arrive precomputed.
module note_channel
  import poly_note_pkg::*;
#(
  parameter int PER_W      = 20,
  parameter int DUR_W      = 16,
  parameter bit IDLE_LEVEL = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             start,
  input  logic             stop,
  input  logic             rest_in,
  input  logic [PER_W-1:0] half_period_in,
  input  logic [DUR_W-1:0] duration_in,
  output logic             busy,
  output logic             done,
  output logic             audio,
  output logic             sounding
);

  ch_state_t        state;
  logic [PER_W-1:0] phase_cnt;
  logic [PER_W-1:0] half_period;
  logic [DUR_W-1:0] ms_cnt;
  logic             rest;

  // Channel FSM: start (re)latches everything and wins over stop; a
  // timed note ends on the tick that would take the countdown to zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= CH_IDLE;
      phase_cnt   <= '0;
      half_period <= '0;
      ms_cnt      <= '0;
      rest        <= 1'b0;
      audio       <= IDLE_LEVEL;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        state       <= CH_PLAY;
        phase_cnt   <= '0;
        half_period <= half_period_in;
        ms_cnt      <= duration_in;
        rest        <= rest_in;
        audio       <= rest_in ? IDLE_LEVEL : 1'b1;
      end else if (state == CH_PLAY) begin
        if (stop) begin
          state     <= CH_IDLE;
          phase_cnt <= '0;
          audio     <= IDLE_LEVEL;
        end else if (tick && ms_cnt == DUR_W'(1)) begin
          state     <= CH_IDLE;
          phase_cnt <= '0;
          ms_cnt    <= '0;
          done      <= 1'b1;
          audio     <= IDLE_LEVEL;
        end else begin
          if (tick && ms_cnt != '0) ms_cnt <= ms_cnt - 1'b1;
          if (phase_cnt == half_period - 1'b1) begin
            phase_cnt <= '0;
            if (!rest) audio <= ~audio;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
      end
    end
  end

  assign busy     = (state == CH_PLAY);
  assign sounding = busy & ~rest & audio;

endmodule

// File: rtl/poly_note_gen.sv
// Multi-channel square-wave tone generator. Owns the shared ms
// prescaler, the per-channel pitch lookup and the registered mix count.
module poly_note_gen
  import poly_note_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int NUM_CH     = 4,
  parameter int PER_W      = 20,
  parameter int DUR_W      = 16,
  parameter bit IDLE_LEVEL = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  poly_note_gen_if.slave bus
);

  localparam int TICK_DIV = CLK_FREQ / 1000;
  localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int MIX_W    = $clog2(NUM_CH + 1);

  logic [TICK_W-1:0] tick_cnt;
  logic              tick;
  logic [NUM_CH-1:0] busy_w;
  logic [NUM_CH-1:0] done_w;
  logic [NUM_CH-1:0] audio_w;
  logic [NUM_CH-1:0] sounding_w;
  logic [MIX_W-1:0]  mix_d;
  logic [MIX_W-1:0]  mix_p1;

  assign tick = (tick_cnt == TICK_W'(TICK_DIV - 1));

  // Free-running millisecond prescaler shared by every channel
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 1'b1;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [3:0]       note;
    logic [2:0]       oct;
    logic             rest;
    logic [PER_W-1:0] hp;

    assign note = bus.note_idx[4*i +: 4];
    assign oct  = bus.octave[3*i +: 3];
    assign rest = (note >= NOTE_REST);
    assign hp   = PER_W'(base_half_period(note) >> clamp_octave(oct));

    note_channel #(
      .PER_W      (PER_W),
      .DUR_W      (DUR_W),
      .IDLE_LEVEL (IDLE_LEVEL)
    ) u_ch (
      .clk            (clk),
      .reset          (reset),
      .tick           (tick),
      .start          (bus.start[i]),
      .stop           (bus.stop[i]),
      .rest_in        (rest),
      .half_period_in (hp),
      .duration_in    (bus.duration[DUR_W*i +: DUR_W]),
      .busy           (busy_w[i]),
      .done           (done_w[i]),
      .audio          (audio_w[i]),
      .sounding       (sounding_w[i])
    );
  end

  // Count channels currently driving a high tone level
  always_comb begin
    mix_d = '0;
    for (int i = 0; i < NUM_CH; i++) mix_d = mix_d + MIX_W'(sounding_w[i]);
  end

  // Mix output register, one cycle behind the channel outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) mix_p1 <= '0;
    else        mix_p1 <= mix_d;
  end

  assign bus.busy      = busy_w;
  assign bus.done      = done_w;
  assign bus.audio_out = audio_w;
  assign bus.audio_mix = mix_p1;

endmodule
